aemb2_dwb_master: RTL and testbench

Synthesizable data-bus initiator on the AEMB2 `dwb` Wishbone-classic interface. It takes byte-addressed load/store commands from a simple command port and runs single, non-pipelined bus cycles. Big-endian lane steering is handled internally: store data is replicated across lanes and load data is right-justified. It is used for bootloaders, DMA-style fill and self-test of `dwb` responders, and drives the same signals the AEMB2 core drives as an initiator.

---
 rtl/aemb2_dwb_pkg.sv | 21 ++
 rtl/aemb2_dwb_lane.sv | 54 +++++
 rtl/aemb2_dwb_master.sv | 169 ++++++++++++++++
 tb/tb_aemb2_dwb_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aemb2_dwb_pkg.sv
// Shared encodings for the AEMB2 dwb initiator.
//   Size encodings of the command port, FSM state type and byte-lane select constants
//   (big-endian: lane 3 = dat[31:24] is the lowest byte address).
package aemb2_dwb_pkg;

  localparam logic [1:0] SIZ_BYTE = 2'b00;
  localparam logic [1:0] SIZ_HALF = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;

  localparam logic [3:0] SEL_BYTE0   = 4'h8;
  localparam logic [3:0] SEL_HALF_HI = 4'hC;
  localparam logic [3:0] SEL_HALF_LO = 4'h3;
  localparam logic [3:0] SEL_WORD    = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

endpackage

// File: rtl/aemb2_dwb_lane.sv
// Combinational big-endian lane steering for the dwb initiator.
//   siz_i      access size (byte/half/word/reserved)
//   off_i      byte offset within the word
//   wdat_i     right-justified store data
//   rdat_i     raw bus read data
//   sel_o      byte-lane selects
//   wdat_o     store data replicated across the lanes
//   rdat_o     load data right-justified, zero-extended
//   misalign_o access cannot be issued (misaligned or reserved size)
module aemb2_dwb_lane
  import aemb2_dwb_pkg::*;
(
  input  logic [1:0]  siz_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdat_i,
  input  logic [31:0] rdat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdat_o,
  output logic [31:0] rdat_o,
  output logic        misalign_o
);

  logic [31:0] byte_sh;

  always_comb begin
    sel_o      = '0;
    wdat_o     = '0;
    rdat_o     = '0;
    misalign_o = 1'b0;
    // Offset o lives in bits [31-8o -: 8], i.e. shift right by 8*(3-o).
    byte_sh    = rdat_i >> {~off_i, 3'b000};
    unique case (siz_i)
      SIZ_BYTE: begin
        sel_o  = SEL_BYTE0 >> off_i;
        wdat_o = {4{wdat_i[7:0]}};
        rdat_o = {24'h0, byte_sh[7:0]};
      end
      SIZ_HALF: begin
        misalign_o = off_i[0];
        sel_o      = off_i[1] ? SEL_HALF_LO : SEL_HALF_HI;
        wdat_o     = {2{wdat_i[15:0]}};
        rdat_o     = {16'h0, (off_i[1] ? rdat_i[15:0] : rdat_i[31:16])};
      end
      SIZ_WORD: begin
        misalign_o = |off_i;
        sel_o      = SEL_WORD;
        wdat_o     = wdat_i;
        rdat_o     = rdat_i;
      end
      default: misalign_o = 1'b1;  // reserved size is rejected like a misalignment
    endcase
  end

endmodule

// File: rtl/aemb2_dwb_master.sv
// AEMB2 dwb Wishbone-classic initiator: runs single non-pipelined load/store cycles
// from a simple command port, with a per-cycle ack timeout.
//   sys_clk_i/sys_rst_i     clock, asynchronous active-low reset
//   cmd_*                   command port (stb/rdy handshake, wre, siz, adr, dat)
//   rsp_stb_o/dat_o/err_o   one-cycle completion pulse with load data / error flag
//   dwb_*                   Wishbone-classic initiator signals (all registered)
module aemb2_dwb_master
  import aemb2_dwb_pkg::*;
#(
  parameter int unsigned DWB = 16,
  parameter int unsigned TMO = 8
) (
  input  logic           sys_clk_i,
  input  logic           sys_rst_i,
  input  logic           cmd_stb_i,
  output logic           cmd_rdy_o,
  input  logic           cmd_wre_i,
  input  logic [1:0]     cmd_siz_i,
  input  logic [DWB-1:0] cmd_adr_i,
  input  logic [31:0]    cmd_dat_i,
  output logic           rsp_stb_o,
  output logic [31:0]    rsp_dat_o,
  output logic           rsp_err_o,
  output logic [DWB-3:0] dwb_adr_o,
  output logic           dwb_cyc_o,
  output logic           dwb_stb_o,
  output logic           dwb_wre_o,
  output logic [3:0]     dwb_sel_o,
  output logic [31:0]    dwb_dat_o,
  input  logic           dwb_ack_i,
  input  logic [31:0]    dwb_dat_i
);

  state_e          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic [TMO-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DWB-3:0]  adr_q, adr_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     dat_q, dat_d;
  logic            wre_q, wre_d;
  logic            stb_q, stb_d;
  logic [1:0]      siz_q, siz_d;
  logic [1:0]      off_q, off_d;
  logic            rsp_stb_q, rsp_stb_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;

  logic [1:0]      lane_siz, lane_off;
  logic [3:0]      lane_sel;
  logic [31:0]     lane_wdat, lane_rdat;
  logic            lane_bad;

  // In IDLE the lane unit decodes the incoming command; during the bus cycle it
  // decodes the captured size/offset so read data is extracted as issued.
  assign lane_siz = (state_q == StIdle) ? cmd_siz_i      : siz_q;
  assign lane_off = (state_q == StIdle) ? cmd_adr_i[1:0] : off_q;

  aemb2_dwb_lane u_lane (
    .siz_i      (lane_siz),
    .off_i      (lane_off),
    .wdat_i     (cmd_dat_i),
    .rdat_i     (dwb_dat_i),
    .sel_o      (lane_sel),
    .wdat_o     (lane_wdat),
    .rdat_o     (lane_rdat),
    .misalign_o (lane_bad)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    wre_d     = wre_q;
    stb_d     = stb_q;
    siz_d     = siz_q;
    off_d     = off_q;
    rsp_stb_d = 1'b0;
    rsp_err_d = 1'b0;
    rsp_dat_d = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_stb_i && rdy_q) begin
          if (lane_bad) begin
            state_d   = StResp;
            rsp_stb_d = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = StBus;
            stb_d   = 1'b1;
            adr_d   = cmd_adr_i[DWB-1:2];
            sel_d   = lane_sel;
            dat_d   = lane_wdat;
            wre_d   = cmd_wre_i;
            siz_d   = cmd_siz_i;
            off_d   = cmd_adr_i[1:0];
            cnt_d   = '0;
          end
        end
      end
      StBus: begin
        // Ack takes priority over a simultaneous terminal count.
        if (dwb_ack_i) begin
          state_d   = StResp;
          stb_d     = 1'b0;
          rsp_stb_d = 1'b1;
          rsp_dat_d = wre_q ? 32'h0 : lane_rdat;
        end else if (cnt_inc == '1) begin
          state_d   = StResp;
          stb_d     = 1'b0;
          rsp_stb_d = 1'b1;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    rdy_d = (state_d == StIdle);
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q   <= StIdle;
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      wre_q     <= 1'b0;
      stb_q     <= 1'b0;
      siz_q     <= '0;
      off_q     <= '0;
      rsp_stb_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      wre_q     <= wre_d;
      stb_q     <= stb_d;
      siz_q     <= siz_d;
      off_q     <= off_d;
      rsp_stb_q <= rsp_stb_d;
      rsp_err_q <= rsp_err_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign cmd_rdy_o = rdy_q;
  assign rsp_stb_o = rsp_stb_q;
  assign rsp_err_o = rsp_err_q;
  assign rsp_dat_o = rsp_dat_q;
  assign dwb_adr_o = adr_q;
  assign dwb_cyc_o = stb_q;
  assign dwb_stb_o = stb_q;
  assign dwb_wre_o = wre_q;
  assign dwb_sel_o = sel_q;
  assign dwb_dat_o = dat_q;

endmodule

// File: tb/tb_aemb2_dwb_master.sv
module tb_aemb2_dwb_master;

  localparam int unsigned DWB = 16;
  localparam int unsigned TMO = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_stb = 1'b0;
  logic           cmd_rdy;
  logic           cmd_wre = 1'b0;
  logic [1:0]     cmd_siz = 2'b00;
  logic [DWB-1:0] cmd_adr = '0;
  logic [31:0]    cmd_dat = '0;
  logic           rsp_stb;
  logic [31:0]    rsp_dat;
  logic           rsp_err;
  logic [DWB-3:0] dwb_adr;
  logic           dwb_cyc;
  logic           dwb_stb;
  logic           dwb_wre;
  logic [3:0]     dwb_sel;
  logic [31:0]    dwb_dat_o;
  logic           dwb_ack = 1'b0;
  logic [31:0]    dwb_dat_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aemb2_dwb_master #(
    .DWB (DWB),
    .TMO (TMO)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst_n),
    .cmd_stb_i (cmd_stb),
    .cmd_rdy_o (cmd_rdy),
    .cmd_wre_i (cmd_wre),
    .cmd_siz_i (cmd_siz),
    .cmd_adr_i (cmd_adr),
    .cmd_dat_i (cmd_dat),
    .rsp_stb_o (rsp_stb),
    .rsp_dat_o (rsp_dat),
    .rsp_err_o (rsp_err),
    .dwb_adr_o (dwb_adr),
    .dwb_cyc_o (dwb_cyc),
    .dwb_stb_o (dwb_stb),
    .dwb_wre_o (dwb_wre),
    .dwb_sel_o (dwb_sel),
    .dwb_dat_o (dwb_dat_o),
    .dwb_ack_i (dwb_ack),
    .dwb_dat_i (dwb_dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for cmd_rdy at a falling edge.
  task automatic wait_rdy(input string tag);
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, cmd_rdy}, 32'h1);
  endtask

  // Present a command for one edge, then scramble the inputs to show they are
  // only sampled at acceptance. Returns at the falling edge after acceptance.
  task automatic issue(input logic wre, input logic [1:0] siz, input logic [DWB-1:0] adr,
                       input logic [31:0] dat);
    cmd_stb = 1'b1;
    cmd_wre = wre;
    cmd_siz = siz;
    cmd_adr = adr;
    cmd_dat = dat;
    @(negedge clk);
    cmd_stb = 1'b0;
    cmd_wre = ~wre;
    cmd_siz = 2'b11;
    cmd_adr = '1;
    cmd_dat = 32'h5A5A_0F0F;
  endtask

  // Ack now; the response is checked at the next falling edge.
  task automatic ack_and_check(input string tag, input logic [31:0] rdata,
                               input logic [31:0] exp_dat);
    dwb_ack   = 1'b1;
    dwb_dat_i = rdata;
    @(negedge clk);
    dwb_ack   = 1'b0;
    dwb_dat_i = 32'h0;
    chk({tag, "_stb_low"}, {31'h0, dwb_stb}, 32'h0);
    chk({tag, "_rsp_stb"}, {31'h0, rsp_stb}, 32'h1);
    chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    chk({tag, "_rsp_dat"}, rsp_dat, exp_dat);
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, {31'h0, rsp_stb}, 32'h0);
    chk({tag, "_rdy_back"}, {31'h0, cmd_rdy}, 32'h1);
  endtask

  logic [3:0] byte_sel_tab [4];
  int         stall;

  initial begin
    byte_sel_tab = '{4'h8, 4'h4, 4'h2, 4'h1};

    // Reset state
    #2;
    chk("rst_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("rst_stb", {30'h0, dwb_stb, dwb_cyc}, 32'h0);
    chk("rst_rsp", {30'h0, rsp_stb, rsp_err}, 32'h0);
    chk("rst_sel", {28'h0, dwb_sel}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {31'h0, cmd_rdy}, 32'h1);

    // Word store, responder acks one cycle late
    issue(1'b1, 2'b10, 16'h0010, 32'hDEAD_BEEF);
    chk("ws_stb", {30'h0, dwb_stb, dwb_cyc}, 32'h3);
    chk("ws_sel", {28'h0, dwb_sel}, 32'hF);
    chk("ws_adr", {18'h0, dwb_adr}, 32'h4);
    chk("ws_dat", dwb_dat_o, 32'hDEAD_BEEF);
    chk("ws_wre", {31'h0, dwb_wre}, 32'h1);
    chk("ws_rdy_low", {31'h0, cmd_rdy}, 32'h0);
    @(negedge clk);
    chk("ws_hold_stb", {31'h0, dwb_stb}, 32'h1);
    chk("ws_hold_adr", {18'h0, dwb_adr}, 32'h4);
    chk("ws_hold_dat", dwb_dat_o, 32'hDEAD_BEEF);
    chk("ws_no_rsp", {31'h0, rsp_stb}, 32'h0);
    ack_and_check("ws", 32'h1234_5678, 32'h0);

    // Byte stores to 0x20..0x23, zero-wait responder
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 2'b00, 16'h0020 + 16'(i), 32'h0000_00A5);
      chk("bs_sel", {28'h0, dwb_sel}, {28'h0, byte_sel_tab[i]});
      chk("bs_dat", dwb_dat_o, 32'hA5A5_A5A5);
      chk("bs_adr", {18'h0, dwb_adr}, 32'h8);
      ack_and_check("bs", 32'h0, 32'h0);
    end

    // Halfword load at 0x32 and 0x30, byte load at 0x21
    issue(1'b0, 2'b01, 16'h0032, 32'h0);
    chk("hl32_sel", {28'h0, dwb_sel}, 32'h3);
    chk("hl32_wre", {31'h0, dwb_wre}, 32'h0);
    chk("hl32_adr", {18'h0, dwb_adr}, 32'hC);
    ack_and_check("hl32", 32'h1122_3344, 32'h0000_3344);
    issue(1'b0, 2'b01, 16'h0030, 32'h0);
    chk("hl30_sel", {28'h0, dwb_sel}, 32'hC);
    ack_and_check("hl30", 32'h1122_3344, 32'h0000_1122);
    issue(1'b0, 2'b00, 16'h0021, 32'h0);
    chk("bl21_sel", {28'h0, dwb_sel}, 32'h4);
    ack_and_check("bl21", 32'h1122_3344, 32'h0000_0022);

    // Ack while idle is ignored
    dwb_ack = 1'b1;
    @(negedge clk);
    dwb_ack = 1'b0;
    chk("idle_ack_rsp", {31'h0, rsp_stb}, 32'h0);
    chk("idle_ack_rdy", {31'h0, cmd_rdy}, 32'h1);

    // Error path: misaligned half, misaligned word, reserved size
    issue(1'b0, 2'b01, 16'h0031, 32'h0);
    chk("mh_stb", {31'h0, dwb_stb}, 32'h0);
    chk("mh_rsp", {30'h0, rsp_stb, rsp_err}, 32'h3);
    chk("mh_dat", rsp_dat, 32'h0);
    @(negedge clk);
    chk("mh_rdy", {31'h0, cmd_rdy}, 32'h1);
    issue(1'b1, 2'b10, 16'h0042, 32'hFFFF_FFFF);
    chk("mw_stb", {31'h0, dwb_stb}, 32'h0);
    chk("mw_rsp", {30'h0, rsp_stb, rsp_err}, 32'h3);
    @(negedge clk);
    issue(1'b0, 2'b11, 16'h0040, 32'h0);
    chk("rs_stb", {31'h0, dwb_stb}, 32'h0);
    chk("rs_rsp", {30'h0, rsp_stb, rsp_err}, 32'h3);
    chk("rs_dat", rsp_dat, 32'h0);
    @(negedge clk);
    chk("rs_rdy", {31'h0, cmd_rdy}, 32'h1);

    // Timeout: responder never acks, 2^4-1 = 15 cycles of strobe
    dwb_dat_i = 32'hFFFF_FFFF;
    issue(1'b0, 2'b10, 16'h0050, 32'h0);
    stall = 0;
    while (dwb_stb === 1'b1 && stall < 40) begin
      stall++;
      @(negedge clk);
    end
    chk("tmo_cycles", stall, 32'd15);
    chk("tmo_rsp", {30'h0, rsp_stb, rsp_err}, 32'h3);
    chk("tmo_dat", rsp_dat, 32'h0);
    chk("tmo_rdy_low", {31'h0, cmd_rdy}, 32'h0);
    @(negedge clk);
    chk("tmo_rdy", {31'h0, cmd_rdy}, 32'h1);
    dwb_dat_i = 32'h0;

    // Asynchronous reset mid-cycle
    issue(1'b1, 2'b10, 16'h0060, 32'h0BAD_F00D);
    chk("ar_stb_pre", {31'h0, dwb_stb}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_stb", {30'h0, dwb_stb, dwb_cyc}, 32'h0);
    chk("ar_wre_sel", {27'h0, dwb_wre, dwb_sel}, 32'h0);
    chk("ar_dat", dwb_dat_o, 32'h0);
    chk("ar_rdy", {31'h0, cmd_rdy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_no_rsp", {31'h0, rsp_stb}, 32'h0);
    wait_rdy("ar_rdy_back");
    issue(1'b0, 2'b10, 16'h0064, 32'h0);
    chk("ar_wl_adr", {18'h0, dwb_adr}, 32'h19);
    chk("ar_wl_sel", {28'h0, dwb_sel}, 32'hF);
    ack_and_check("ar_wl", 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
